pkt_reader: RTL and testbench

Egress-side consumer of the packet control memory. Given the head block address of a stored packet, it walks the control-memory linked list, streams each block's 32-byte segment out of data memory as 32-bit words on a ready/valid port, and returns every consumed block to the allocator through the allocator's `free_en`/`free_addr` pulse interface. It sits directly downstream of the block allocator: the allocator builds chains, `pkt_reader` drains and releases them.

---
 rtl/pkt_pkg.sv | 22 ++
 rtl/pkt_reader_if.sv | 12 +
 rtl/fifo2.sv | 73 +++++++
 rtl/pkt_reader.sv | 180 ++++++++++++++++++
 tb/tb_pkt_reader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared constants and reader state encoding for the packet path
package pkt_pkg;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;
    localparam int CTRL_W      = ADDR_W + 1;
    localparam int ALLOC_BIT   = ADDR_W;
    localparam int BLOCK_WORDS = 8;
    localparam int FREE_GAP    = 3;
    localparam int MAX_BLOCKS  = 63;

    localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_LINK,
        RD_LINK_WAIT,
        RD_DATA,
        RD_FREE
    } rd_state_e;

endpackage

// File: rtl/pkt_reader_if.sv
// rtl/pkt_reader_if.sv - egress word stream (valid/ready with last marker)
interface pkt_reader_if #(
    parameter int DATA_W = pkt_pkg::DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fifo2.sv
// rtl/fifo2.sv - two-entry FIFO with head held in a register and occupancy output
module fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    // slot0 is always the head so the output comes straight from a flop
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 2'd0);
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, do_pop})
                2'b01: begin
                    slot0_d = slot1_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        slot0_d = din;
                        cnt_d   = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        slot1_d = din;
                        cnt_d   = 2'd2;
                    end
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        slot0_d = din;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = slot0_q;
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/pkt_reader.sv
// rtl/pkt_reader.sv - walks a control-memory block chain, streams block data and frees each block
module pkt_reader #(
    parameter int ADDR_W      = pkt_pkg::ADDR_W,
    parameter int DATA_W      = pkt_pkg::DATA_W,
    parameter int BLOCK_WORDS = pkt_pkg::BLOCK_WORDS,
    parameter int FREE_GAP    = pkt_pkg::FREE_GAP,
    parameter int MAX_BLOCKS  = pkt_pkg::MAX_BLOCKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cmem_rd_en,
    output logic [ADDR_W-1:0] cmem_addr,
    input  logic [ADDR_W:0]   cmem_q,
    output logic              dmem_rd_en,
    output logic [ADDR_W+2:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_q,
    pkt_reader_if.master      out_if,
    output logic              free_en,
    output logic [ADDR_W-1:0] free_addr
);

    localparam int WIDX_W = 3;
    localparam int CNT_W  = $clog2(MAX_BLOCKS + 1);
    localparam int GAP_W  = (FREE_GAP > 1) ? $clog2(FREE_GAP) : 1;
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] NULL_A    = ADDR_W'(pkt_pkg::NULL_ADDR);

    typedef pkt_pkg::rd_state_e state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0]  nxt_q, nxt_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_last_q, rd_last_d;
    logic               err_hold_q, err_hold_d;

    logic               abort;
    logic               fifo_flush;
    logic               fifo_pop;
    logic               fifo_valid;
    logic [1:0]         fifo_count;
    logic [DATA_W:0]    fifo_dout;
    logic [2:0]         occ_after_pop;
    logic               can_issue;

    fifo2 #(.WIDTH(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (fifo_flush),
        .push  (rd_pend_q),
        .din   ({rd_last_q, dmem_q}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign fifo_pop         = fifo_valid && out_if.out_ready;
    assign out_if.out_valid = fifo_valid;
    assign out_if.out_data  = fifo_dout[DATA_W-1:0];
    assign out_if.out_last  = fifo_valid && fifo_dout[DATA_W];

    // reads in flight land a cycle later, so they count against the two slots
    assign occ_after_pop = {1'b0, fifo_count} - {2'b0, fifo_pop} + {2'b0, rd_pend_q};
    assign can_issue     = (occ_after_pop < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= pkt_pkg::RD_IDLE;
            cur_q      <= '0;
            nxt_q      <= '0;
            blk_cnt_q  <= '0;
            widx_q     <= '0;
            gap_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            err_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            blk_cnt_q  <= blk_cnt_d;
            widx_q     <= widx_d;
            gap_q      <= gap_d;
            rd_pend_q  <= rd_pend_d;
            rd_last_q  <= rd_last_d;
            err_hold_q <= err_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        blk_cnt_d  = blk_cnt_q;
        widx_d     = widx_q;
        gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        err_hold_d = 1'b0;
        rd_last_d  = 1'b0;
        cmem_rd_en = 1'b0;
        cmem_addr  = '0;
        dmem_rd_en = 1'b0;
        dmem_addr  = '0;
        free_en    = 1'b0;
        free_addr  = '0;
        done       = 1'b0;
        abort      = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            pkt_pkg::RD_IDLE: begin
                if (start && !fifo_valid) begin
                    if (head_addr == NULL_A) begin
                        err_hold_d = 1'b1;
                    end else begin
                        cur_d     = head_addr;
                        blk_cnt_d = '0;
                        state_d   = pkt_pkg::RD_LINK;
                    end
                end
            end
            pkt_pkg::RD_LINK: begin
                cmem_rd_en = 1'b1;
                cmem_addr  = cur_q;
                state_d    = pkt_pkg::RD_LINK_WAIT;
            end
            pkt_pkg::RD_LINK_WAIT: begin
                if (!cmem_q[ADDR_W] || (blk_cnt_q == CNT_W'(MAX_BLOCKS))) begin
                    abort      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = pkt_pkg::RD_IDLE;
                end else begin
                    nxt_d     = cmem_q[ADDR_W-1:0];
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    widx_d    = '0;
                    state_d   = pkt_pkg::RD_DATA;
                end
            end
            pkt_pkg::RD_DATA: begin
                if (can_issue) begin
                    dmem_rd_en = 1'b1;
                    dmem_addr  = {cur_q, widx_q};
                    rd_last_d  = (widx_q == LAST_WIDX) && (nxt_q == NULL_A);
                    widx_d     = widx_q + WIDX_W'(1);
                    if (widx_q == LAST_WIDX) begin
                        state_d = pkt_pkg::RD_FREE;
                    end
                end
            end
            pkt_pkg::RD_FREE: begin
                if (gap_q == '0) begin
                    free_en   = 1'b1;
                    free_addr = cur_q;
                    gap_d     = GAP_W'(FREE_GAP - 1);
                    if (nxt_q == NULL_A) begin
                        done    = 1'b1;
                        state_d = pkt_pkg::RD_IDLE;
                    end else begin
                        cur_d   = nxt_q;
                        state_d = pkt_pkg::RD_LINK;
                    end
                end
            end
            default: state_d = pkt_pkg::RD_IDLE;
        endcase
    end

    assign rd_pend_d = dmem_rd_en;
    assign busy      = (state_q != pkt_pkg::RD_IDLE);
    assign err       = err_hold_q | abort;

endmodule

// File: tb/tb_pkt_reader.sv
// tb/tb_pkt_reader.sv - scoreboard bench for pkt_reader with control/data memory models
module tb_pkt_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  head_addr;
    logic        busy, done, err;
    logic        cmem_rd_en;
    logic [9:0]  cmem_addr;
    logic [10:0] cmem_q;
    logic        dmem_rd_en;
    logic [12:0] dmem_addr;
    logic [31:0] dmem_q;
    logic        free_en;
    logic [9:0]  free_addr;

    pkt_reader_if #(.DATA_W(32)) out_if ();

    pkt_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .head_addr  (head_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cmem_rd_en (cmem_rd_en),
        .cmem_addr  (cmem_addr),
        .cmem_q     (cmem_q),
        .dmem_rd_en (dmem_rd_en),
        .dmem_addr  (dmem_addr),
        .dmem_q     (dmem_q),
        .out_if     (out_if),
        .free_en    (free_en),
        .free_addr  (free_addr)
    );

    always #5 clk = ~clk;

    logic [10:0] cmem [0:1023];

    always @(posedge clk) begin
        if (cmem_rd_en) cmem_q <= cmem[cmem_addr];
        if (dmem_rd_en) dmem_q <= 32'hA500_0000 | {19'd0, dmem_addr};
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          rel;
    int          pidx;
    bit          toggle_mode = 1'b0;
    logic [3:0]  pat = 4'b1001;
    logic [32:0] exp_q [$];
    logic [9:0]  exp_free [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: words, frees and pulse counts
    always @(negedge clk) begin
        if (!reset) begin
            if (out_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {31'd0, out_if.out_last, out_if.out_data}, 64'h1_FFFF_FFFF_FFFF);
                end else begin
                    chk("word", {31'd0, out_if.out_last, out_if.out_data}, {31'd0, exp_q[0]});
                    if (out_if.out_ready) void'(exp_q.pop_front());
                end
            end
            if (free_en) begin
                if (exp_free.size() == 0) begin
                    chk("unexpected_free", {54'd0, free_addr}, 64'hFFFF);
                end else begin
                    chk("free_addr", {54'd0, free_addr}, {54'd0, exp_free[0]});
                    void'(exp_free.pop_front());
                end
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        rel++;
        if (toggle_mode) begin
            out_if.out_ready = pat[pidx];
            pidx = (pidx + 1) % 4;
        end else begin
            out_if.out_ready = 1'b1;
        end
    endtask

    task automatic goto(input int c);
        while (rel < c) tick();
    endtask

    task automatic kick(input int h);
        rel       = 0;
        start     = 1'b1;
        head_addr = 10'(h);
        tick();
        start     = 1'b0;
        head_addr = '0;
    endtask

    task automatic cm(input int a, input bit alloc, input int n);
        cmem[a] = {alloc, 10'(n)};
    endtask

    task automatic push_block(input int a, input bit last_blk);
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back({(last_blk && w == 7), 32'hA500_0000 | 32'(a * 8 + w)});
        end
        exp_free.push_back(10'(a));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || out_if.out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(n), 64'(budget - 1));
        tick();
        tick();
    endtask

    task automatic run_single;
        int d0;
        d0 = done_cnt;
        cm(5, 1'b1, 0);
        push_block(5, 1'b1);
        kick(5);
        chk("c1_cmem_rd_en", 64'(cmem_rd_en), 64'd1);
        chk("c1_cmem_addr", 64'(cmem_addr), 64'd5);
        chk("c1_busy", 64'(busy), 64'd1);
        goto(3);
        chk("c3_dmem_rd_en", 64'(dmem_rd_en), 64'd1);
        chk("c3_dmem_addr", 64'(dmem_addr), 64'd40);
        goto(5);
        chk("c5_out_valid", 64'(out_if.out_valid), 64'd1);
        chk("c5_out_data", 64'(out_if.out_data), 64'hA500_0028);
        goto(11);
        chk("c11_free_en", 64'(free_en), 64'd1);
        chk("c11_free_addr", 64'(free_addr), 64'd5);
        chk("c11_done", 64'(done), 64'd1);
        goto(12);
        chk("c12_out_last", 64'(out_if.out_last), 64'd1);
        goto(13);
        chk("c13_busy", 64'(busy), 64'd0);
        chk("c13_out_valid", 64'(out_if.out_valid), 64'd0);
        wait_idle(50);
        chk("single_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("single_words_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        reset            = 1'b1;
        start            = 1'b0;
        head_addr        = '0;
        out_if.out_ready = 1'b1;
        pidx             = 0;
        rel              = 0;
        for (int i = 0; i < 1024; i++) cmem[i] = '0;

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", {58'd0, done, err, cmem_rd_en, dmem_rd_en, free_en, out_if.out_valid}, 64'd0);
        chk("rst_out_data", 64'(out_if.out_data), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // single-block packet with cycle-exact timing
        run_single();

        // three-block chain 1 -> 2 -> 7
        cm(1, 1'b1, 2);
        cm(2, 1'b1, 7);
        cm(7, 1'b1, 0);
        push_block(1, 1'b0);
        push_block(2, 1'b0);
        push_block(7, 1'b1);
        d0 = done_cnt;
        kick(1);
        wait_idle(300);
        chk("chain_words_left", 64'(exp_q.size()), 64'd0);
        chk("chain_frees_left", 64'(exp_free.size()), 64'd0);
        chk("chain_done_cnt", 64'(done_cnt - d0), 64'd1);

        // back-pressure 1,0,0,1 on a two-block chain
        toggle_mode = 1'b1;
        pidx        = 0;
        cm(3, 1'b1, 4);
        cm(4, 1'b1, 0);
        push_block(3, 1'b0);
        push_block(4, 1'b1);
        d0 = done_cnt;
        kick(3);
        wait_idle(400);
        toggle_mode = 1'b0;
        tick();
        chk("bp_words_left", 64'(exp_q.size()), 64'd0);
        chk("bp_frees_left", 64'(exp_free.size()), 64'd0);
        chk("bp_done_cnt", 64'(done_cnt - d0), 64'd1);

        // unallocated link at block 2
        cm(1, 1'b1, 2);
        cm(2, 1'b0, 3);
        push_block(1, 1'b0);
        d0 = done_cnt;
        e0 = err_cnt;
        kick(1);
        goto(13);
        chk("unalloc_err_c13", 64'(err), 64'd1);
        wait_idle(100);
        chk("unalloc_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("unalloc_done_cnt", 64'(done_cnt - d0), 64'd0);
        chk("unalloc_words_left", 64'(exp_q.size()), 64'd0);
        chk("unalloc_frees_left", 64'(exp_free.size()), 64'd0);

        // null head
        e0 = err_cnt;
        kick(0);
        chk("null_err_c1", 64'(err), 64'd1);
        chk("null_busy_c1", 64'(busy), 64'd0);
        chk("null_cmem_rd_c1", 64'(cmem_rd_en), 64'd0);
        tick();
        chk("null_err_c2", 64'(err), 64'd0);
        chk("null_err_cnt", 64'(err_cnt - e0), 64'd1);

        // 64-block cyclic chain 100..163 -> 100
        for (int i = 0; i < 64; i++) cm(100 + i, 1'b1, 100 + ((i + 1) % 64));
        for (int i = 0; i < 63; i++) push_block(100 + i, 1'b0);
        d0 = done_cnt;
        e0 = err_cnt;
        kick(100);
        wait_idle(1500);
        chk("cyc_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("cyc_done_cnt", 64'(done_cnt - d0), 64'd0);
        chk("cyc_words_left", 64'(exp_q.size()), 64'd0);
        chk("cyc_frees_left", 64'(exp_free.size()), 64'd0);

        // reset in the middle of DATA, then a clean restart
        cm(5, 1'b1, 0);
        push_block(5, 1'b1);
        kick(5);
        goto(6);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_outs", {59'd0, dmem_rd_en, cmem_rd_en, free_en, done, out_if.out_valid}, 64'd0);
        chk("mid_rst_out_data", 64'(out_if.out_data), 64'd0);
        exp_q.delete();
        exp_free.delete();
        tick();
        reset = 1'b0;
        tick();
        run_single();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
